// File: rtl/pscan_pkg.sv
// Shared definitions for the perfect-number range sweep controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: sweep FSM state enum, default widths and the default watchdog limit.
package pscan_pkg;

  localparam int PSCAN_W       = 16;    // candidate width, matches engine sw bus
  localparam int PSCAN_CW      = 8;     // hit counter width
  localparam int PSCAN_TIMEOUT = 4096;  // per-candidate watchdog limit (cycles)

  typedef enum logic [2:0] {
    IDLE,
    SKIPCHK,
    ISSUE,
    RELEASE,
    ADVANCE,
    FINISH
  } pscan_state_t;

endpackage

// File: rtl/pscan_hit_counter.sv
// Saturating hit counter for the sweep controller.
// Latency: count reflects clr/inc on the following clock edge.
// Backpressure: none; sticks at all-ones instead of wrapping.
// Ports: clk, rst_n (async active-low), clr (sync clear, wins over inc),
//        inc (count one hit), count (current value).
module pscan_hit_counter
  import pscan_pkg::*;
#(
  parameter int CW = PSCAN_CW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          inc,
  output logic [CW-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + CW'(1);
    end
  end

endmodule

// File: rtl/perfect_scan_ctrl.sv
// Range sweep controller: issues candidates lo..hi to one perfect-number engine and counts hits.
// Latency: min 4 cycles per issued candidate plus engine run time; done pulses one cycle after FINISH.
// Backpressure: waits on the engine go/over level handshake; abort only honoured between candidates.
// Ports: clk, rst_n (async active-low); start/abort/lo/hi from host; eng_sw/eng_go to engine,
//        eng_over/eng_ans from engine; busy/done/range_err/hit/hit_val/count/aborted status.
// Optional: define PSCAN_TIMEOUT_EN to add a per-candidate watchdog of TIMEOUT cycles.
module perfect_scan_ctrl
  import pscan_pkg::*;
#(
  parameter int W       = PSCAN_W,
  parameter int CW      = PSCAN_CW,
  parameter int TIMEOUT = PSCAN_TIMEOUT
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          abort,
  input  logic [W-1:0]  lo,
  input  logic [W-1:0]  hi,
  output logic [W-1:0]  eng_sw,
  output logic          eng_go,
  input  logic          eng_over,
  input  logic          eng_ans,
  output logic          busy,
  output logic          done,
  output logic          range_err,
  output logic          hit,
  output logic [W-1:0]  hit_val,
  output logic [CW-1:0] count,
  output logic          aborted
);

  pscan_state_t state;
  logic [W-1:0] cur;
  logic [W-1:0] hi_q;
  logic         cnt_clr;
  logic         cnt_inc;

`ifdef PSCAN_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT + 1);
  logic [WD_W-1:0] wd;
  logic            wd_expired;
  assign wd_expired = (wd == WD_W'(TIMEOUT - 1));
`else
  localparam int unused_timeout = TIMEOUT;
`endif

  // Any start seen in IDLE begins a new sweep report, including a rejected range.
  assign cnt_clr = (state == IDLE) && start;
  assign cnt_inc = (state == ISSUE) && eng_over && eng_ans;

  pscan_hit_counter #(.CW(CW)) u_hit_counter (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (cnt_clr),
    .inc   (cnt_inc),
    .count (count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cur       <= '0;
      hi_q      <= '0;
      eng_sw    <= '0;
      eng_go    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      range_err <= 1'b0;
      hit       <= 1'b0;
      hit_val   <= '0;
      aborted   <= 1'b0;
`ifdef PSCAN_TIMEOUT_EN
      wd        <= '0;
`endif
    end else begin
      done <= 1'b0;
      hit  <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            aborted <= 1'b0;
            if (lo > hi) begin
              // Rejected range still reports completion through FINISH.
              range_err <= 1'b1;
              state     <= FINISH;
            end else begin
              range_err <= 1'b0;
              hi_q      <= hi;
              cur       <= lo;
              busy      <= 1'b1;
              state     <= SKIPCHK;
            end
          end
        end

        SKIPCHK: begin
          // 0 and 1 are not perfect and the engine is never asked about them.
          if (cur < W'(2)) begin
            state <= ADVANCE;
          end else begin
            // eng_sw only changes here, so it is frozen for the whole go phase.
            eng_sw <= cur;
            eng_go <= 1'b1;
            state  <= ISSUE;
`ifdef PSCAN_TIMEOUT_EN
            wd     <= '0;
`endif
          end
        end

        ISSUE: begin
          if (eng_over) begin
            eng_go <= 1'b0;
            if (eng_ans) begin
              hit     <= 1'b1;
              hit_val <= cur;
            end
            state <= RELEASE;
`ifdef PSCAN_TIMEOUT_EN
            wd    <= '0;
          end else if (wd_expired) begin
            aborted <= 1'b1;
            eng_go  <= 1'b0;
            state   <= FINISH;
          end else begin
            wd <= wd + WD_W'(1);
`endif
          end
        end

        RELEASE: begin
          // Engine only returns to idle after seeing go low.
          if (!eng_over) begin
            state <= ADVANCE;
`ifdef PSCAN_TIMEOUT_EN
          end else if (wd_expired) begin
            aborted <= 1'b1;
            state   <= FINISH;
          end else begin
            wd <= wd + WD_W'(1);
`endif
          end
        end

        ADVANCE: begin
          // Compare before increment so hi = all-ones ends without wrapping.
          if (abort) begin
            aborted <= 1'b1;
            state   <= FINISH;
          end else if (cur == hi_q) begin
            state <= FINISH;
          end else begin
            cur   <= cur + W'(1);
            state <= SKIPCHK;
          end
        end

        FINISH: begin
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= IDLE;
        end

        default: begin
          eng_go <= 1'b0;
          busy   <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_perfect_scan_ctrl.sv
// Self-checking bench for perfect_scan_ctrl with a randomized-latency behavioural engine.
// Latency: engine answers 3..20 cycles after go rises and drops over one cycle after go falls.
// Backpressure: engine holds over until go falls; optional hang mode never answers.
module tb_perfect_scan_ctrl;

  localparam int W  = 16;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [W-1:0]  lo = '0;
  logic [W-1:0]  hi = '0;
  logic [W-1:0]  eng_sw;
  logic          eng_go;
  logic          eng_over;
  logic          eng_ans;
  logic          busy;
  logic          done;
  logic          range_err;
  logic          hit;
  logic [W-1:0]  hit_val;
  logic [CW-1:0] count;
  logic          aborted;

  int n_vec = 0;
  int n_err = 0;

  // model state
  int  issued[$];
  int  sw_lo, sw_hi;
  int  mdl_count;
  int  done_cnt;
  logic       prev_go;
  logic [W-1:0] prev_sw;
  logic hang = 1'b0;

  perfect_scan_ctrl #(.W(W), .CW(CW), .TIMEOUT(64)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .abort     (abort),
    .lo        (lo),
    .hi        (hi),
    .eng_sw    (eng_sw),
    .eng_go    (eng_go),
    .eng_over  (eng_over),
    .eng_ans   (eng_ans),
    .busy      (busy),
    .done      (done),
    .range_err (range_err),
    .hit       (hit),
    .hit_val   (hit_val),
    .count     (count),
    .aborted   (aborted)
  );

  always #5 clk = ~clk;

  function automatic logic is_perfect(input int n);
    int s;
    if (n < 2) return 1'b0;
    s = 1;
    for (int d = 2; d * d <= n; d++) begin
      if (n % d == 0) begin
        s += d;
        if (d != n / d) s += n / d;
      end
    end
    return (s == n);
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Behavioural engine
  logic eng_run;
  int   eng_lat;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      eng_over <= 1'b0;
      eng_ans  <= 1'b0;
      eng_run  <= 1'b0;
      eng_lat  <= 0;
    end else if (hang) begin
      eng_over <= 1'b0;
      eng_run  <= 1'b0;
    end else if (!eng_run && !eng_over && eng_go) begin
      eng_run <= 1'b1;
      eng_lat <= $urandom_range(20, 3) - 1;
    end else if (eng_run) begin
      if (eng_lat <= 1) begin
        eng_run  <= 1'b0;
        eng_over <= 1'b1;
        eng_ans  <= is_perfect(int'(eng_sw));
      end else begin
        eng_lat <= eng_lat - 1;
      end
    end else if (eng_over && !eng_go) begin
      eng_over <= 1'b0;
      eng_ans  <= 1'b0;
    end
  end

  // Compare process: issue order, sw stability, hit legality and running count.
  always @(negedge clk) begin
    int exp_sw;
    if (rst_n) begin
      if (eng_go) begin
        if (!prev_go) begin
          if (issued.size() == 0) exp_sw = (sw_lo < 2) ? 2 : sw_lo;
          else                    exp_sw = issued[$] + 1;
          check("issue_seq", 32'(eng_sw), 32'(exp_sw));
          check("issue_le_hi", 32'(int'(eng_sw) <= sw_hi), 32'd1);
          issued.push_back(int'(eng_sw));
        end else begin
          check("sw_stable", 32'(eng_sw), 32'(prev_sw));
        end
      end
      if (hit) begin
        check("hit_perfect", 32'(is_perfect(int'(hit_val))), 32'd1);
        if (issued.size() == 0) check("hit_without_issue", 32'd1, 32'd0);
        else                    check("hit_val_is_cur", 32'(hit_val), 32'(issued[$]));
        if (mdl_count < (1 << CW) - 1) mdl_count++;
      end
      if (busy || done) check("count_run", 32'(count), 32'(mdl_count));
      if (done) done_cnt++;
      prev_go = eng_go;
      prev_sw = eng_sw;
    end else begin
      prev_go = 1'b0;
    end
  end

  task automatic do_start(input int l, input int h);
    sw_lo = l;
    sw_hi = h;
    issued.delete();
    mdl_count = 0;
    done_cnt  = 0;
    @(negedge clk);
    lo    = W'(l);
    hi    = W'(h);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (!done && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (!done) check("done_timeout", 32'd0, 32'd1);
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_go(input int budget);
    int n = 0;
    while (!eng_go && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (!eng_go) check("go_timeout", 32'd0, 32'd1);
  endtask

  function automatic int model_hits();
    int c = 0;
    foreach (issued[i]) if (is_perfect(issued[i])) c++;
    return c;
  endfunction

  initial begin
    #900000;
    $display("FAIL global_watchdog: got no finish expected finish");
    $fatal(1, "bench timed out");
  end

  initial begin
    int n;
    // reset state
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_go", 32'(eng_go), 32'd0);
    check("rst_sw", 32'(eng_sw), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // 1..30: hits at 6 and 28, candidate 1 never issued
    do_start(1, 30);
    check("t1_busy", 32'(busy), 32'd1);
    wait_done(3000);
    check("t1_count", 32'(count), 32'd2);
    check("t1_hit_val", 32'(hit_val), 32'd28);
    check("t1_done_once", 32'(done_cnt), 32'd1);
    check("t1_n_issued", 32'(issued.size()), 32'd29);
    check("t1_model_hits", 32'(model_hits()), 32'd2);
    check("t1_aborted", 32'(aborted), 32'd0);
    check("t1_busy_end", 32'(busy), 32'd0);

    // lo>hi: range_err, done one cycle later, nothing issued
    do_start(500, 496);
    check("t2_range_err", 32'(range_err), 32'd1);
    check("t2_done_early", 32'(done), 32'd0);
    @(negedge clk);
    check("t2_done", 32'(done), 32'd1);
    @(negedge clk);
    check("t2_done_pulse", 32'(done), 32'd0);
    repeat (2) @(negedge clk);
    check("t2_count", 32'(count), 32'd0);
    check("t2_no_issue", 32'(issued.size()), 32'd0);
    check("t2_busy", 32'(busy), 32'd0);
    check("t2_done_once", 32'(done_cnt), 32'd1);

    // top of range: no wrap
    do_start(65530, 65535);
    check("t3_range_err_clr", 32'(range_err), 32'd0);
    wait_done(1000);
    check("t3_n_issued", 32'(issued.size()), 32'd6);
    check("t3_last", 32'(issued[$]), 32'd65535);
    check("t3_count", 32'(count), 32'd0);
    check("t3_done_once", 32'(done_cnt), 32'd1);
    check("t3_busy", 32'(busy), 32'd0);

    // abort while issuing 497
    do_start(2, 10000);
    n = 0;
    while (!(hit && hit_val == W'(496)) && n < 30000) begin
      @(negedge clk);
      n++;
    end
    check("t4_reached_496", 32'(hit && hit_val == W'(496)), 32'd1);
    wait_go(100);
    abort = 1'b1;
    wait_done(200);
    abort = 1'b0;
    check("t4_aborted", 32'(aborted), 32'd1);
    check("t4_count", 32'(count), 32'd3);
    check("t4_hit_val", 32'(hit_val), 32'd496);
    check("t4_last", 32'(issued[$]), 32'd497);
    check("t4_go", 32'(eng_go), 32'd0);
    check("t4_done_once", 32'(done_cnt), 32'd1);

    // async reset during ISSUE
    do_start(2, 100);
    wait_go(100);
    #2 rst_n = 1'b0;
    #1;
    check("t5_go", 32'(eng_go), 32'd0);
    check("t5_busy", 32'(busy), 32'd0);
    check("t5_sw", 32'(eng_sw), 32'd0);
    check("t5_hit_val", 32'(hit_val), 32'd0);
    check("t5_aborted", 32'(aborted), 32'd0);
    check("t5_count", 32'(count), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    do_start(6, 6);
    wait_done(200);
    check("t5_count_after", 32'(count), 32'd1);
    check("t5_hit_val_after", 32'(hit_val), 32'd6);
    check("t5_done_once", 32'(done_cnt), 32'd1);

`ifdef PSCAN_TIMEOUT_EN
    // engine never answers: watchdog ends the sweep after 64 go cycles
    hang = 1'b1;
    do_start(10, 12);
    wait_go(20);
    n = 0;
    while (eng_go && n < 500) begin
      n++;
      @(negedge clk);
    end
    check("t6_go_cycles", 32'(n), 32'd64);
    wait_done(50);
    check("t6_aborted", 32'(aborted), 32'd1);
    check("t6_go", 32'(eng_go), 32'd0);
    check("t6_done_once", 32'(done_cnt), 32'd1);
    hang = 1'b0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
